// File: rtl/enemy_spawn_controller.sv
// Spawn/update sequencer for the enemy position handler: LFSR spawn X, frame ticks, miss counting.
// Optional ENEMY_PAUSE_EN adds a pause input that freezes the frame counter while waiting.
module enemy_spawn_controller #(
  parameter int TICK_DIV   = 833333,
  parameter int X_MAX      = 151,
  parameter int MAX_MISS   = 5,
  parameter int SPAWN_STEP = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
`ifdef ENEMY_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       reachBottom,
  output logic       inResete,
  output logic       inUpdateE,
  output logic [7:0] enemyXInput,
  output logic [3:0] speedIn,
  output logic [3:0] missed,
  output logic       game_over,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_WAIT, S_UPDATE, S_CHECK, S_OVER
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SPAWN_STEP > 1) ? $clog2(SPAWN_STEP) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_STEP - 1);
  localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISS);

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    x_q, x_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] spawn_q, spawn_d;
  logic [3:0]    speed_q, speed_d;
  logic [3:0]    missed_q, missed_d;
  logic          resete_q, resete_d;
  logic          update_q, update_d;
  logic          over_q, over_d;
  logic          pause_w;
  logic [7:0]    x_map;

`ifdef ENEMY_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // Fold LFSR values above X_MAX back into the legal spawn range.
  assign x_map = (lfsr_q <= 8'(X_MAX)) ? lfsr_q : lfsr_q - 8'(X_MAX + 1);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    x_d      = x_q;
    tick_d   = tick_q;
    spawn_d  = spawn_q;
    speed_d  = speed_q;
    missed_d = missed_q;

    if (state_q == S_SPAWN) begin
      tick_d = '0;
      if (spawn_q == SPAWN_LAST) begin
        spawn_d = '0;
        if (speed_q != 4'd3) speed_d = speed_q + 4'd1;
      end else begin
        spawn_d = spawn_q + SW'(1);
      end
    end

    if (!start && state_q != S_OVER) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_SPAWN;
        S_SPAWN:  state_d = S_WAIT;
        S_WAIT: begin
          if (hit) begin
            state_d = S_SPAWN;
          end else if (!pause_w) begin
            if (tick_q == TICK_LAST) begin
              tick_d  = '0;
              state_d = S_UPDATE;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        S_UPDATE: state_d = S_CHECK;
        S_CHECK: begin
          // A hit in the same cycle as reachBottom means the enemy was destroyed.
          if (hit) begin
            state_d = S_SPAWN;
          end else if (reachBottom) begin
            missed_d = missed_q + 4'd1;
            state_d  = (missed_d == MISS_LIMIT) ? S_OVER : S_SPAWN;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_OVER: begin
          if (!start) begin
            state_d  = S_IDLE;
            missed_d = '0;
            spawn_d  = '0;
            speed_d  = 4'd1;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end

    if (state_d == S_SPAWN && state_q != S_SPAWN) x_d = x_map;
    resete_d = (state_d == S_SPAWN);
    update_d = (state_d == S_UPDATE);
    over_d   = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= 8'hA5;
      x_q      <= '0;
      tick_q   <= '0;
      spawn_q  <= '0;
      speed_q  <= 4'd1;
      missed_q <= '0;
      resete_q <= 1'b0;
      update_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      x_q      <= x_d;
      tick_q   <= tick_d;
      spawn_q  <= spawn_d;
      speed_q  <= speed_d;
      missed_q <= missed_d;
      resete_q <= resete_d;
      update_q <= update_d;
      over_q   <= over_d;
    end
  end

  assign inResete    = resete_q;
  assign inUpdateE   = update_q;
  assign enemyXInput = x_q;
  assign speedIn     = speed_q;
  assign missed      = missed_q;
  assign game_over   = over_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_enemy_spawn_controller.sv
// Bench for enemy_spawn_controller: frame-position model compared every cycle plus directed literals.
// Define ENEMY_PAUSE_EN for both bench and RTL to exercise the pause input.
module tb_enemy_spawn_controller;
  localparam int TICK_DIV   = 4;
  localparam int X_MAX      = 151;
  localparam int MAX_MISS   = 2;
  localparam int SPAWN_STEP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       pause = 1'b0;
  logic       rb = 1'b0;
  logic       inResete, inUpdateE, game_over;
  logic [7:0] enemyXInput;
  logic [3:0] speedIn, missed;
  logic [2:0] state_dbg;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  enemy_spawn_controller #(
    .TICK_DIV(TICK_DIV), .X_MAX(X_MAX), .MAX_MISS(MAX_MISS), .SPAWN_STEP(SPAWN_STEP)
  ) dut (
    .clk(clk),
    .reset(rst),
    .start(start),
    .hit(hit),
`ifdef ENEMY_PAUSE_EN
    .pause(pause),
`endif
    .reachBottom(rb),
    .inResete(inResete),
    .inUpdateE(inUpdateE),
    .enemyXInput(enemyXInput),
    .speedIn(speedIn),
    .missed(missed),
    .game_over(game_over),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- model ----------------
  // Game tracked as a mode plus a position inside the current frame:
  // pos 0 = spawn cycle, 1..TICK_DIV = waiting, TICK_DIV+1 = update, TICK_DIV+2 = check.
  int         m_mode;   // 0 idle, 1 running, 2 over
  int         m_pos, m_spawns, m_missed;
  logic [7:0] m_lfsr, m_x;
  logic       pause_eff;

`ifdef ENEMY_PAUSE_EN
  assign pause_eff = pause;
`else
  assign pause_eff = 1'b0;
`endif

  function automatic logic [7:0] xmap(input logic [7:0] v);
    return (v <= 8'(X_MAX)) ? v : v - 8'(X_MAX + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [7:0] cur;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_spawns = 0; m_missed = 0;
      m_lfsr = 8'hA5; m_x = 8'h00;
    end else begin
      cur = m_lfsr;
      m_lfsr = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
      if (m_mode == 1 && m_pos == 0) m_spawns++;
      if (m_mode == 2) begin
        if (!start) begin m_mode = 0; m_missed = 0; m_spawns = 0; end
      end else if (!start) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_pos = 0; m_x = xmap(cur);
      end else if (m_pos == 0) begin
        m_pos = 1;
      end else if (m_pos <= TICK_DIV) begin
        if (hit) begin m_pos = 0; m_x = xmap(cur); end
        else if (!pause_eff) m_pos++;
      end else if (m_pos == TICK_DIV + 1) begin
        m_pos++;
      end else begin
        if (hit) begin
          m_pos = 0; m_x = xmap(cur);
        end else if (rb) begin
          m_missed++;
          if (m_missed == MAX_MISS) m_mode = 2;
          else begin m_pos = 0; m_x = xmap(cur); end
        end else begin
          m_pos = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [18:0] act, exp;
    int sp;
    if (chk_en) begin
      sp = 1 + m_spawns / SPAWN_STEP;
      if (sp > 3) sp = 3;
      exp = {(m_mode == 1 && m_pos == 0), (m_mode == 1 && m_pos == TICK_DIV + 1),
             (m_mode == 2), 4'(m_missed), 4'(sp), m_x};
      act = {inResete, inUpdateE, game_over, missed, speedIn, enemyXInput};
      chk("cycle_outputs", int'(act), int'(exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_update(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (inUpdateE) return;
    end
    chk("wait_update_timeout", 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, cnt, seen;
    int speed_tab[4];
    speed_tab = '{1, 2, 3, 3};

    tick(); tick();
    chk_en = 1'b1;
    chk("reset_speed", speedIn, 1);
    chk("reset_pulses", {inResete, inUpdateE, game_over}, 0);
    chk("reset_x", enemyXInput, 0);
    chk("reset_missed", missed, 0);

    // First spawn maps 8'hA5 to 165-152.
    rst = 1'b0; start = 1'b1;
    tick();
    chk("t1_spawn_pulse", inResete, 1);
    chk("t1_spawn_x", enemyXInput, 13);
    wait_update(n);
    chk("t1_spawn_to_update", n, TICK_DIV + 1);
    tick();
    tick();
    chk("t1_check_to_wait", {inResete, inUpdateE}, 0);

    // Frame length from the first WAIT cycle, then the first miss.
    rb = 1'b1;
    wait_update(n);
    chk("t2_wait_to_update", n, TICK_DIV);
    tick(); tick();
    chk("t2_miss1", missed, 1);
    chk("t2_respawn", inResete, 1);

    // hit and reachBottom together in CHECK: respawn, no miss.
    wait_update(n);
    tick();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    chk("t3_hit_respawn", inResete, 1);
    chk("t3_missed_kept", missed, 1);

    // Second miss ends the game.
    wait_update(n);
    tick(); tick();
    chk("t2_miss2", missed, 2);
    chk("t2_game_over", game_over, 1);
    chk("t2_no_spawn_in_over", inResete, 0);
    rb = 1'b0;
    tick(); tick();
    chk("t2_over_holds", game_over, 1);
    start = 1'b0;
    tick();
    chk("t2_over_exit", game_over, 0);
    chk("t2_missed_clear", missed, 0);

    // Speed ramp by hits, then 255 spawns through the whole LFSR cycle.
    start = 1'b1;
    tick(); tick();
    chk("t4_speed_0", speedIn, speed_tab[0]);
    for (int k = 1; k <= 6; k++) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
      chk("t4_hit_spawn", inResete, 1);
      tick();
      if (k % 2 == 0) chk("t4_speed", speedIn, speed_tab[k / 2]);
    end
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
      if (inResete) cnt++;
      tick();
    end
    chk("t4_spawn_count", cnt, 255);
    start = 1'b0;
    tick();
    chk("t4_idle_pulses", {inResete, inUpdateE}, 0);
    chk("t4_idle_keeps_speed", speedIn, 3);

    // Asynchronous reset in the middle of WAIT.
    start = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_async_pulses", {inResete, inUpdateE, game_over}, 0);
    chk("t5_async_speed", speedIn, 1);
    chk("t5_async_x", enemyXInput, 0);
    tick();
    rst = 1'b0;
    chk("t5_idle_after_reset", inResete, 0);
    tick();
    chk("t5_resume_spawn", inResete, 1);
    chk("t5_resume_x", enemyXInput, 13);

`ifdef ENEMY_PAUSE_EN
    // Pause after two WAIT cycles; three more edges reach UPDATE afterwards.
    tick(); tick();
    pause = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inUpdateE) seen++;
    end
    chk("t6_no_update_paused", seen, 0);
    pause = 1'b0;
    wait_update(n);
    chk("t6_resume_count", n, TICK_DIV - 1);
`else
    seen = 0;
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
